// File: rtl/ibex_dummy_instr_retire.sv
// Tags issued instructions as real/dummy, suppresses dummy retire,
// counts retirements and raises encode/cadence/tracking alerts.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   dummy_instr_en_i      dummy insertion enabled
//   dummy_instr_mask_i    cadence mask (sets the real-issue gap bound)
//   issue_valid_i         instruction leaves ID this cycle
//   issue_dummy_i         issued instruction is a dummy
//   issue_instr_i         issued instruction word
//   wb_done_i             oldest in-flight instruction completes writeback
//   flush_i               discard all in-flight tags
//   retire_o              real instruction retired (combinational)
//   dummy_retire_o        dummy instruction retired (combinational)
//   instr_cnt_o           saturating real retire count
//   dummy_cnt_o           saturating dummy retire count
//   encode_alert_o        pulse: malformed dummy issued
//   gap_alert_o           pulse: dummy cadence bound exceeded
//   track_err_o           sticky: tag FIFO overflow or underflow
module ibex_dummy_instr_retire #(
    parameter int unsigned DEPTH         = 2,
    parameter int unsigned CNT_W         = 32,
    parameter int unsigned TIMEOUT_CNT_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             dummy_instr_en_i,
    input  logic [2:0]       dummy_instr_mask_i,
    input  logic             issue_valid_i,
    input  logic             issue_dummy_i,
    input  logic [31:0]      issue_instr_i,
    input  logic             wb_done_i,
    input  logic             flush_i,
    output logic             retire_o,
    output logic             dummy_retire_o,
    output logic [CNT_W-1:0] instr_cnt_o,
    output logic [CNT_W-1:0] dummy_cnt_o,
    output logic             encode_alert_o,
    output logic             gap_alert_o,
    output logic             track_err_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned OW = PW + 1;
    localparam int unsigned GW = TIMEOUT_CNT_W + 1;

    logic [DEPTH-1:0] r_tags;
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [OW-1:0]    r_occ;
    logic [CNT_W-1:0] r_instr_cnt;
    logic [CNT_W-1:0] r_dummy_cnt;
    logic [GW-1:0]    r_gap;
    logic             r_enc_alert;
    logic             r_gap_alert;
    logic             r_track_err;

    logic             w_empty;
    logic             w_full;
    logic             w_head_vld;
    logic             w_head_tag;
    logic             w_push;
    logic             w_pop;
    logic             w_ovf;
    logic             w_unf;
    logic [6:0]       w_f7;
    logic [2:0]       w_f3;
    logic             w_legal;
    logic             w_enc_bad;
    logic [GW-1:0]    w_bound;
    logic [GW-1:0]    w_gap_d;
    logic             w_gap_hit;

    assign w_empty = (r_occ == '0);
    assign w_full  = (r_occ == OW'(DEPTH));

    // An empty FIFO with a same-cycle issue retires the incoming tag.
    assign w_head_vld = !w_empty | issue_valid_i;
    assign w_head_tag = w_empty ? issue_dummy_i : r_tags[r_rptr];

    assign w_pop  = wb_done_i & w_head_vld;
    assign w_push = issue_valid_i & (!w_full | wb_done_i);
    assign w_ovf  = issue_valid_i & w_full & !wb_done_i;
    assign w_unf  = wb_done_i & w_empty & !issue_valid_i;

    assign retire_o       = wb_done_i & w_head_vld & !w_head_tag;
    assign dummy_retire_o = wb_done_i & w_head_vld & w_head_tag;

    assign w_f7 = issue_instr_i[31:25];
    assign w_f3 = issue_instr_i[14:12];

    assign w_legal = (issue_instr_i[6:0] == 7'h33)
                   & (issue_instr_i[11:7] == 5'd0)
                   & (((w_f7 == 7'h00) & ((w_f3 == 3'b000) | (w_f3 == 3'b111)))
                   |  ((w_f7 == 7'h01) & ((w_f3 == 3'b000) | (w_f3 == 3'b100))));

    assign w_enc_bad = issue_valid_i & issue_dummy_i
                     & (!dummy_instr_en_i | !w_legal);

    assign w_bound = {1'b0, dummy_instr_mask_i, {(TIMEOUT_CNT_W-3){1'b1}}};

    // Past the bound the gap parks at B+1 so only one alert fires per run.
    always_comb begin
        w_gap_d   = r_gap;
        w_gap_hit = 1'b0;
        if (!dummy_instr_en_i) begin
            w_gap_d = '0;
        end else if (issue_valid_i) begin
            if (issue_dummy_i) begin
                w_gap_d = '0;
            end else if (r_gap == w_bound) begin
                w_gap_hit = 1'b1;
                w_gap_d   = w_bound + GW'(1);
            end else if (r_gap < w_bound) begin
                w_gap_d = r_gap + GW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_tags <= '0;
            r_wptr <= '0;
            r_rptr <= '0;
            r_occ  <= '0;
        end else if (flush_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_occ  <= '0;
        end else begin
            if (w_push) begin
                r_tags[r_wptr] <= issue_dummy_i;
                r_wptr         <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            r_occ <= r_occ + OW'(w_push) - OW'(w_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_instr_cnt <= '0;
            r_dummy_cnt <= '0;
            r_gap       <= '0;
            r_enc_alert <= 1'b0;
            r_gap_alert <= 1'b0;
            r_track_err <= 1'b0;
        end else begin
            if (retire_o && !(&r_instr_cnt)) begin
                r_instr_cnt <= r_instr_cnt + CNT_W'(1);
            end
            if (dummy_retire_o && !(&r_dummy_cnt)) begin
                r_dummy_cnt <= r_dummy_cnt + CNT_W'(1);
            end
            r_gap       <= w_gap_d;
            r_enc_alert <= w_enc_bad;
            r_gap_alert <= w_gap_hit;
            if (w_ovf || w_unf) begin
                r_track_err <= 1'b1;
            end
        end
    end

    assign instr_cnt_o    = r_instr_cnt;
    assign dummy_cnt_o    = r_dummy_cnt;
    assign encode_alert_o = r_enc_alert;
    assign gap_alert_o    = r_gap_alert;
    assign track_err_o    = r_track_err;

endmodule

// File: tb/tb_ibex_dummy_instr_retire.sv
// Randomized and directed bench for ibex_dummy_instr_retire,
// checked against a queue-based reference model.
module tb_ibex_dummy_instr_retire;

    localparam int DEPTH = 2;
    localparam int CNT_W = 4;
    localparam int TW    = 5;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [2:0]       mask;
    logic             iv;
    logic             id;
    logic [31:0]      ins;
    logic             wb;
    logic             fl;
    logic             ret;
    logic             dret;
    logic [CNT_W-1:0] icnt;
    logic [CNT_W-1:0] dcnt;
    logic             enc_a;
    logic             gap_a;
    logic             terr;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit q[$];
    int m_icnt;
    int m_dcnt;
    int m_gap;
    bit m_enc;
    bit m_gapa;
    bit m_err;

    always #5 clk = ~clk;

    ibex_dummy_instr_retire #(
        .DEPTH(DEPTH), .CNT_W(CNT_W), .TIMEOUT_CNT_W(TW)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .dummy_instr_en_i(en), .dummy_instr_mask_i(mask),
        .issue_valid_i(iv), .issue_dummy_i(id), .issue_instr_i(ins),
        .wb_done_i(wb), .flush_i(fl),
        .retire_o(ret), .dummy_retire_o(dret),
        .instr_cnt_o(icnt), .dummy_cnt_o(dcnt),
        .encode_alert_o(enc_a), .gap_alert_o(gap_a), .track_err_o(terr)
    );

    function automatic bit legal(logic [31:0] w);
        logic [6:0] f7;
        logic [2:0] f3;
        f7 = w[31:25];
        f3 = w[14:12];
        if (w[6:0] != 7'h33 || w[11:7] != 5'd0) return 0;
        if (f7 == 7'h00 && (f3 == 3'd0 || f3 == 3'd7)) return 1;
        if (f7 == 7'h01 && (f3 == 3'd0 || f3 == 3'd4)) return 1;
        return 0;
    endfunction

    task automatic model_reset();
        q.delete();
        m_icnt = 0; m_dcnt = 0; m_gap = 0;
        m_enc = 0; m_gapa = 0; m_err = 0;
    endtask

    task automatic do_reset();
        rst = 1; iv = 0; id = 0; ins = '0; wb = 0; fl = 0;
        @(posedge clk); #1;
        rst = 0;
        model_reset();
    endtask

    // Apply one cycle of stimulus, return observed and modelled
    // combinational retire outputs, and advance the model.
    task automatic step(input bit s_iv, input bit s_id,
                        input logic [31:0] s_ins, input bit s_wb,
                        input bit s_fl,
                        output logic o_ret, output logic o_dret,
                        output bit e_ret, output bit e_dret);
        bit hv;
        bit tag;
        bit bypass;
        int bound;
        iv = s_iv; id = s_id; ins = s_ins; wb = s_wb; fl = s_fl;
        #1;
        o_ret  = ret;
        o_dret = dret;
        hv  = (q.size() > 0) || s_iv;
        tag = (q.size() > 0) ? q[0] : s_id;
        e_ret  = s_wb && hv && !tag;
        e_dret = s_wb && hv && tag;
        if ((s_iv && q.size() == DEPTH && !s_wb) ||
            (s_wb && q.size() == 0 && !s_iv)) m_err = 1;
        if (e_ret)  m_icnt = (m_icnt < CMAX) ? m_icnt + 1 : CMAX;
        if (e_dret) m_dcnt = (m_dcnt < CMAX) ? m_dcnt + 1 : CMAX;
        if (s_fl) begin
            q.delete();
        end else begin
            bypass = 0;
            if (s_wb && q.size() > 0) void'(q.pop_front());
            else if (s_wb && s_iv) bypass = 1;
            if (s_iv && !bypass && q.size() < DEPTH) q.push_back(s_id);
        end
        m_enc  = s_iv && s_id && (!en || !legal(s_ins));
        m_gapa = 0;
        bound  = int'(mask) * 4 + 3;
        if (!en) m_gap = 0;
        else if (s_iv) begin
            if (s_id) m_gap = 0;
            else if (m_gap == bound) begin m_gapa = 1; m_gap = bound + 1; end
            else if (m_gap < bound) m_gap = m_gap + 1;
        end
        @(posedge clk); #1;
        iv = 0; id = 0; ins = '0; wb = 0; fl = 0;
    endtask

    task automatic test_reset();
        logic o_r, o_d;
        do_reset();
        #1;
        o_r = ret; o_d = dret;
        checks++; if (o_r !== 1'b0) begin errors++; $display("FAIL reset_ret got %b want 0", o_r); end
        checks++; if (o_d !== 1'b0) begin errors++; $display("FAIL reset_dret got %b want 0", o_d); end
        checks++; if (icnt !== '0) begin errors++; $display("FAIL reset_icnt got %0d want 0", icnt); end
        checks++; if (dcnt !== '0) begin errors++; $display("FAIL reset_dcnt got %0d want 0", dcnt); end
        checks++; if (enc_a !== 1'b0) begin errors++; $display("FAIL reset_enc got %b want 0", enc_a); end
        checks++; if (gap_a !== 1'b0) begin errors++; $display("FAIL reset_gap got %b want 0", gap_a); end
        checks++; if (terr !== 1'b0) begin errors++; $display("FAIL reset_terr got %b want 0", terr); end
    endtask

    task automatic test_basic();
        logic o_r, o_d;
        bit e_r, e_d;
        bit want_r[3] = '{1, 0, 1};
        bit want_d[3] = '{0, 1, 0};
        int k = 0;
        en = 1; mask = 3'b111;
        do_reset();
        step(1, 0, 32'h0000_0013, 0, 0, o_r, o_d, e_r, e_d);
        step(1, 1, 32'h0200_4033, 0, 0, o_r, o_d, e_r, e_d);
        step(1, 0, 32'h0000_0013, 1, 0, o_r, o_d, e_r, e_d);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) step(0, 0, '0, 1, 0, o_r, o_d, e_r, e_d);
            checks++;
            if (o_r !== logic'(want_r[k]) || o_d !== logic'(want_d[k])) begin
                errors++;
                $display("FAIL basic_retire%0d got %b/%b want %b/%b", k, o_r, o_d, want_r[k], want_d[k]);
            end
            k++;
        end
        checks++; if (icnt !== 4'd2) begin errors++; $display("FAIL basic_icnt got %0d want 2", icnt); end
        checks++; if (dcnt !== 4'd1) begin errors++; $display("FAIL basic_dcnt got %0d want 1", dcnt); end
        checks++;
        if (enc_a !== 1'b0 || gap_a !== 1'b0 || terr !== 1'b0) begin
            errors++;
            $display("FAIL basic_alerts got %b%b%b want 000", enc_a, gap_a, terr);
        end
    endtask

    task automatic test_gap();
        logic o_r, o_d;
        bit e_r, e_d;
        en = 1; mask = 3'b000;
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            step(1, 0, 32'h0000_0013, 1, 0, o_r, o_d, e_r, e_d);
            checks++;
            if (gap_a !== logic'(i == 4)) begin
                errors++; $display("FAIL gap_run1_%0d got %b want %b", i, gap_a, i == 4);
            end
        end
        step(1, 1, 32'h0000_0033, 1, 0, o_r, o_d, e_r, e_d);
        checks++;
        if (gap_a !== 1'b0 || enc_a !== 1'b0) begin
            errors++; $display("FAIL gap_dummy got %b%b want 00", gap_a, enc_a);
        end
        for (int i = 1; i <= 4; i++) begin
            step(1, 0, 32'h0000_0013, 1, 0, o_r, o_d, e_r, e_d);
            checks++;
            if (gap_a !== logic'(i == 4)) begin
                errors++; $display("FAIL gap_run2_%0d got %b want %b", i, gap_a, i == 4);
            end
        end
        en = 0;
        for (int i = 1; i <= 5; i++) begin
            step(1, 0, 32'h0000_0013, 1, 0, o_r, o_d, e_r, e_d);
            checks++;
            if (gap_a !== 1'b0) begin errors++; $display("FAIL gap_dis_%0d got %b want 0", i, gap_a); end
        end
        en = 1;
        for (int i = 1; i <= 4; i++) begin
            step(1, 0, 32'h0000_0013, 1, 0, o_r, o_d, e_r, e_d);
            checks++;
            if (gap_a !== logic'(i == 4)) begin
                errors++; $display("FAIL gap_run3_%0d got %b want %b", i, gap_a, i == 4);
            end
        end
    endtask

    task automatic test_encode();
        logic o_r, o_d;
        bit e_r, e_d;
        en = 1; mask = 3'b111;
        do_reset();
        step(1, 1, 32'h0000_50B3, 1, 0, o_r, o_d, e_r, e_d);
        checks++;
        if (o_d !== 1'b1 || o_r !== 1'b0) begin
            errors++; $display("FAIL enc_dret got %b/%b want 0/1", o_r, o_d);
        end
        checks++; if (enc_a !== 1'b1) begin errors++; $display("FAIL enc_pulse got %b want 1", enc_a); end
        checks++; if (dcnt !== 4'd1) begin errors++; $display("FAIL enc_dcnt got %0d want 1", dcnt); end
        step(0, 0, '0, 0, 0, o_r, o_d, e_r, e_d);
        checks++; if (enc_a !== 1'b0) begin errors++; $display("FAIL enc_clear got %b want 0", enc_a); end
        step(1, 1, 32'h0000_7033, 1, 0, o_r, o_d, e_r, e_d);
        checks++; if (enc_a !== 1'b0) begin errors++; $display("FAIL enc_legal got %b want 0", enc_a); end
        en = 0;
        step(1, 1, 32'h0000_0033, 1, 0, o_r, o_d, e_r, e_d);
        checks++; if (enc_a !== 1'b1) begin errors++; $display("FAIL enc_disabled got %b want 1", enc_a); end
        en = 1;
    endtask

    task automatic test_track_err();
        logic o_r, o_d;
        bit e_r, e_d;
        do_reset();
        step(1, 0, '0, 0, 0, o_r, o_d, e_r, e_d);
        step(1, 1, 32'h0000_0033, 0, 0, o_r, o_d, e_r, e_d);
        checks++; if (terr !== 1'b0) begin errors++; $display("FAIL ovf_early got %b want 0", terr); end
        step(1, 0, '0, 0, 0, o_r, o_d, e_r, e_d);
        checks++; if (terr !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", terr); end
        step(0, 0, '0, 0, 0, o_r, o_d, e_r, e_d);
        checks++; if (terr !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", terr); end
        do_reset();
        checks++; if (terr !== 1'b0) begin errors++; $display("FAIL err_reset got %b want 0", terr); end
        step(0, 0, '0, 1, 0, o_r, o_d, e_r, e_d);
        checks++;
        if (o_r !== 1'b0 || o_d !== 1'b0) begin
            errors++; $display("FAIL unf_retire got %b/%b want 0/0", o_r, o_d);
        end
        checks++; if (terr !== 1'b1) begin errors++; $display("FAIL unf_set got %b want 1", terr); end
    endtask

    task automatic test_flush();
        logic o_r, o_d;
        bit e_r, e_d;
        en = 1; mask = 3'b111;
        do_reset();
        step(1, 0, '0, 0, 0, o_r, o_d, e_r, e_d);
        step(1, 1, 32'h0000_0033, 0, 0, o_r, o_d, e_r, e_d);
        step(1, 1, 32'h0000_0033, 1, 1, o_r, o_d, e_r, e_d);
        checks++;
        if (o_r !== 1'b1 || o_d !== 1'b0) begin
            errors++; $display("FAIL flush_head got %b/%b want 1/0", o_r, o_d);
        end
        checks++; if (icnt !== 4'd1) begin errors++; $display("FAIL flush_icnt got %0d want 1", icnt); end
        checks++; if (terr !== 1'b0) begin errors++; $display("FAIL flush_err got %b want 0", terr); end
        step(0, 0, '0, 1, 0, o_r, o_d, e_r, e_d);
        checks++;
        if (o_r !== 1'b0 || o_d !== 1'b0) begin
            errors++; $display("FAIL flush_empty got %b/%b want 0/0", o_r, o_d);
        end
        checks++; if (terr !== 1'b1) begin errors++; $display("FAIL flush_unf got %b want 1", terr); end
    endtask

    task automatic test_saturate();
        logic o_r, o_d;
        bit e_r, e_d;
        en = 1; mask = 3'b111;
        do_reset();
        for (int i = 0; i < CMAX + 5; i++) step(1, 0, '0, 1, 0, o_r, o_d, e_r, e_d);
        checks++;
        if (icnt !== CNT_W'(CMAX)) begin
            errors++; $display("FAIL sat_icnt got %0d want %0d", icnt, CMAX);
        end
        for (int i = 0; i < CMAX + 5; i++) step(1, 1, 32'h0000_0033, 1, 0, o_r, o_d, e_r, e_d);
        checks++;
        if (dcnt !== CNT_W'(CMAX)) begin
            errors++; $display("FAIL sat_dcnt got %0d want %0d", dcnt, CMAX);
        end
    endtask

    task automatic test_random();
        logic o_r, o_d;
        bit e_r, e_d;
        bit r_iv, r_id, r_wb, r_fl;
        logic [31:0] w;
        en = 1; mask = 3'b001;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            if ($urandom_range(0, 24) == 0) begin
                en   = ($urandom_range(0, 3) != 0);
                mask = 3'($urandom_range(0, 7));
            end
            r_iv = ($urandom_range(0, 9) < 7);
            r_id = ($urandom_range(0, 9) < 3);
            r_wb = ($urandom_range(0, 9) < 6);
            r_fl = ($urandom_range(0, 19) == 0);
            w = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                w[6:0] = 7'h33; w[11:7] = 5'd0;
                w[25] = $urandom_range(0, 1) == 1;
                w[31:26] = '0;
                w[14:12] = w[25] ? ($urandom_range(0, 1) ? 3'd0 : 3'd4)
                                 : ($urandom_range(0, 1) ? 3'd0 : 3'd7);
                if ($urandom_range(0, 4) == 0) w[14:12] = 3'($urandom_range(0, 7));
            end
            step(r_iv, r_id, w, r_wb, r_fl, o_r, o_d, e_r, e_d);
            checks++;
            if (o_r !== logic'(e_r) || o_d !== logic'(e_d)) begin
                errors++; $display("FAIL rnd_retire@%0d got %b/%b want %b/%b", n, o_r, o_d, e_r, e_d);
            end
            checks++;
            if (icnt !== CNT_W'(m_icnt) || dcnt !== CNT_W'(m_dcnt)) begin
                errors++; $display("FAIL rnd_cnt@%0d got %0d/%0d want %0d/%0d", n, icnt, dcnt, m_icnt, m_dcnt);
            end
            checks++;
            if (enc_a !== logic'(m_enc) || gap_a !== logic'(m_gapa) || terr !== logic'(m_err)) begin
                errors++;
                $display("FAIL rnd_flags@%0d got %b%b%b want %b%b%b", n, enc_a, gap_a, terr, m_enc, m_gapa, m_err);
            end
        end
    endtask

    initial begin
        en = 1; mask = 3'b111;
        iv = 0; id = 0; ins = '0; wb = 0; fl = 0; rst = 1;
        model_reset();
        test_reset();
        test_basic();
        test_gap();
        test_encode();
        test_track_err();
        test_flush();
        test_saturate();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
